reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
// - Consumes the debounced/delayed system reset request and releases board resets in order:
//   peripherals, then memory init, then CPU.
// - Waits for PLL lock before any release.
// - Re-asserts every reset when a new request arrives or lock is lost.
// - Sits between the reset-delay stage and the PicoRV core, bus peripherals and RAM initialiser.
// PARAMETERS
// - CNT_W          16    width of the shared down-counter
// - HOLD_CYCLES    16    consecutive cycles with req_rst_i low before leaving HOLD
// - PERIPH_CYCLES  8     cycles peripherals run out of reset before memory init starts
// - CPU_CYCLES     4     cycles after mem_done_i before CPU release
// - TIMEOUT_CYCLES 4096  maximum wait for mem_done_i
// - Constraint: every *_CYCLES value is >= 1 and <= 2**CNT_W-1.
// PORTS
// - clk_i          in   1  system clock; single clock domain
// - rst_ni         in   1  synchronous, active-low reset
// - req_rst_i      in   1  reset request from the delay stage; 1 = hold the system in reset
// - pll_lock_i     in   1  PLL locked, already synchronous to clk_i
// - mem_done_i     in   1  RAM initialiser finished (level or pulse)
// - periph_rstn_o  out  1  peripheral reset, active-low
// - mem_start_o    out  1  one-cycle start pulse to the RAM initialiser
// - cpu_rstn_o     out  1  CPU reset, active-low
// - ready_o        out  1  1 only in RUN
// - timeout_o      out  1  sticky; memory init timed out
// - state_o        out  3  current state encoding, for debug/LEDs
// BEHAVIOUR
// - All outputs registered.
// - rst_ni=0 at a clock edge forces:
//   - state HOLD, counter=HOLD_CYCLES-1
//   - periph_rstn_o=0, cpu_rstn_o=0, mem_start_o=0, ready_o=0, timeout_o=0
// - States: HOLD=0, LOCK=1, PERIPH=2, MEMINIT=3, CPUDLY=4, RUN=5, FAULT=6.
// - Priority per edge: rst_ni low > abort > normal transition.
// - Abort: req_rst_i=1, or pll_lock_i=0 in any state other than HOLD/LOCK.
//   - Next state HOLD; both rstn outputs 0 and ready_o 0 on that same edge (1-cycle latency).
// - HOLD:
//   - counter reloads HOLD_CYCLES-1 while req_rst_i=1, otherwise decrements.
//   - counter==0 && req_rst_i==0 -> LOCK; timeout_o cleared on this exit.
// - LOCK: pll_lock_i=1 -> PERIPH; periph_rstn_o=1 on that edge; counter loaded PERIPH_CYCLES-1.
// - PERIPH:
//   - counter==0 -> MEMINIT; mem_start_o=1 for exactly that one cycle.
//   - counter loaded TIMEOUT_CYCLES-1.
// - MEMINIT:
//   - mem_done_i is ignored in the cycle where mem_start_o=1.
//   - mem_done_i=1 afterwards -> CPUDLY, counter=CPU_CYCLES-1.
//   - Else counter==0 -> FAULT with timeout_o=1.
//   - mem_done_i wins if it coincides with counter==0.
// - CPUDLY: counter==0 -> RUN; cpu_rstn_o=1 and ready_o=1 on that edge.
// - RUN: stays until an abort.
// - FAULT: periph_rstn_o stays 1, cpu_rstn_o stays 0; left only by an abort or rst_ni.
// - pll_lock_i falling in LOCK is not an abort; LOCK simply keeps waiting.
// - Simultaneous req_rst_i=1 and pll loss: single abort, identical result.
// - Counter never wraps: it decrements only when nonzero and only in timed states.
// STRUCTURE
// - Shared include reset_seq_defs.vh: state-encoding localparams (3-bit), default cycle constants.
// - One sub-module, seq_timer: CNT_W loadable down-counter with load/enable inputs and zero_o.
// - FSM and output registers stay in reset_sequencer.
// TESTING
// - Power-up: rst_ni=0 for 2 cycles, then 1; req=0, lock=1, mem_done 5 cycles after start.
//   -> periph_rstn_o rises 17 cycles after rst_ni release; mem_start_o pulses 8 cycles later;
//      cpu_rstn_o/ready_o rise 4 cycles after mem_done_i sampled.
// - req_rst_i held high 40 cycles while in RUN.
//   -> all rstn low and ready_o low on the next edge;
//      after release, the full sequence restarts with 16-cycle HOLD.
// - req_rst_i glitches low for 10 cycles during HOLD.
//   -> counter reloads; state stays HOLD; no release until 16 consecutive low cycles.
// - pll_lock_i drops for 1 cycle in CPUDLY.
//   -> HOLD next edge, periph_rstn_o=0; relock -> sequence repeats.
// - mem_done_i never asserted.
//   -> FAULT exactly 4096 cycles after the start pulse; timeout_o=1;
//      cpu_rstn_o stays 0; req pulse -> HOLD; timeout_o clears on exit to LOCK.
// - mem_done_i asserted in the same cycle as mem_start_o and then dropped -> ignored, ends in FAULT;
//   mem_done_i on the final timeout cycle -> CPUDLY, no timeout.

Source files
------------

// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_sequencer_pkg
// Shared definitions for the board reset sequencer:
//   - state_e      : 3-bit state encoding, also driven out on state_o for LEDs
//   - DEF_*        : default counter width and cycle constants
//   - is_timed     : states in which the shared down-counter runs
//   - abort_exempt : states in which losing PLL lock is not an abort
// -----------------------------------------------------------------------------
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_LOCK    = 3'd1,
        ST_PERIPH  = 3'd2,
        ST_MEMINIT = 3'd3,
        ST_CPUDLY  = 3'd4,
        ST_RUN     = 3'd5,
        ST_FAULT   = 3'd6
    } state_e;

    localparam int DEF_CNT_W          = 16;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_PERIPH_CYCLES  = 8;
    localparam int DEF_CPU_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // The counter only moves in states that measure an interval.
    function automatic logic is_timed(input state_e st);
        logic timed_s;
        case (st)
            ST_HOLD, ST_PERIPH, ST_MEMINIT, ST_CPUDLY: timed_s = 1'b1;
            default:                                   timed_s = 1'b0;
        endcase
        return timed_s;
    endfunction

    // Before any release the PLL may come and go without restarting the sequence.
    function automatic logic abort_exempt(input state_e st);
        logic exempt_s;
        case (st)
            ST_HOLD, ST_LOCK: exempt_s = 1'b1;
            default:          exempt_s = 1'b0;
        endcase
        return exempt_s;
    endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Loadable down-counter shared by all timed states of the reset sequencer.
// Ports:
//   clk_i       in   clock
//   rst_ni      in   synchronous active-low reset, loads RST_VAL
//   load_i      in   load load_val_i (has priority over en_i)
//   load_val_i  in   value to load
//   en_i        in   decrement enable; the counter saturates at zero
//   zero_o      out  counter is zero
// -----------------------------------------------------------------------------
module seq_timer #(
    parameter int               CNT_W   = 16,
    parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_r;
    logic             zero_s;

    assign zero_s = (cnt_r == {CNT_W{1'b0}});
    assign zero_o = zero_s;

    // Counter register: reset load, explicit load, or saturating decrement.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r <= RST_VAL;
        end else if (load_i) begin
            cnt_r <= load_val_i;
        end else if (en_i && !zero_s) begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Releases board resets in order (peripherals, RAM init, CPU) once the reset
// request has been low long enough and the PLL is locked. Any new request, or
// loss of lock after release has begun, drops every reset again.
// Ports:
//   clk_i          in   system clock
//   rst_ni         in   synchronous active-low reset
//   req_rst_i      in   reset request from the delay stage (1 = hold in reset)
//   pll_lock_i     in   PLL locked, synchronous to clk_i
//   mem_done_i     in   RAM initialiser finished
//   periph_rstn_o  out  peripheral reset, active-low
//   mem_start_o    out  one-cycle start pulse to the RAM initialiser
//   cpu_rstn_o     out  CPU reset, active-low
//   ready_o        out  high only in RUN
//   timeout_o      out  sticky RAM-init timeout flag
//   state_o        out  current state encoding
// -----------------------------------------------------------------------------
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int CNT_W          = DEF_CNT_W,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int PERIPH_CYCLES  = DEF_PERIPH_CYCLES,
    parameter int CPU_CYCLES     = DEF_CPU_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_rst_i,
    input  logic       pll_lock_i,
    input  logic       mem_done_i,
    output logic       periph_rstn_o,
    output logic       mem_start_o,
    output logic       cpu_rstn_o,
    output logic       ready_o,
    output logic       timeout_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIPH_LOAD  = CNT_W'(PERIPH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LOAD     = CNT_W'(CPU_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             periph_rstn_r;
    logic             periph_rstn_nxt_s;
    logic             mem_start_r;
    logic             mem_start_nxt_s;
    logic             cpu_rstn_r;
    logic             cpu_rstn_nxt_s;
    logic             ready_r;
    logic             ready_nxt_s;
    logic             timeout_r;
    logic             timeout_nxt_s;

    logic             abort_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_load_val_s;
    logic             tmr_en_s;
    logic             tmr_zero_s;

    seq_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (HOLD_LOAD)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_load_val_s),
        .en_i       (tmr_en_s),
        .zero_o     (tmr_zero_s)
    );

    // A request or a lost PLL (once past LOCK) restarts from HOLD; both together are one abort.
    assign abort_s = req_rst_i | (~pll_lock_i & ~abort_exempt(state_r));

    // Next-state, next-output and timer-control decode.
    always_comb begin
        state_nxt_s       = state_r;
        periph_rstn_nxt_s = periph_rstn_r;
        mem_start_nxt_s   = 1'b0;
        cpu_rstn_nxt_s    = cpu_rstn_r;
        ready_nxt_s       = ready_r;
        timeout_nxt_s     = timeout_r;
        tmr_load_s        = 1'b0;
        tmr_load_val_s    = HOLD_LOAD;
        tmr_en_s          = is_timed(state_r);

        if (abort_s) begin
            state_nxt_s       = ST_HOLD;
            periph_rstn_nxt_s = 1'b0;
            cpu_rstn_nxt_s    = 1'b0;
            ready_nxt_s       = 1'b0;
            tmr_load_s        = 1'b1;
            tmr_load_val_s    = HOLD_LOAD;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    periph_rstn_nxt_s = 1'b0;
                    cpu_rstn_nxt_s    = 1'b0;
                    ready_nxt_s       = 1'b0;
                    if (tmr_zero_s) begin
                        state_nxt_s   = ST_LOCK;
                        timeout_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s   = ST_HOLD;
                    end
                end
                ST_LOCK: begin
                    if (pll_lock_i) begin
                        state_nxt_s       = ST_PERIPH;
                        periph_rstn_nxt_s = 1'b1;
                        tmr_load_s        = 1'b1;
                        tmr_load_val_s    = PERIPH_LOAD;
                    end else begin
                        state_nxt_s       = ST_LOCK;
                    end
                end
                ST_PERIPH: begin
                    if (tmr_zero_s) begin
                        state_nxt_s     = ST_MEMINIT;
                        mem_start_nxt_s = 1'b1;
                        tmr_load_s      = 1'b1;
                        tmr_load_val_s  = TIMEOUT_LOAD;
                    end else begin
                        state_nxt_s     = ST_PERIPH;
                    end
                end
                ST_MEMINIT: begin
                    // A done seen while the start pulse is still out belongs to a previous run.
                    if (mem_done_i && !mem_start_r) begin
                        state_nxt_s    = ST_CPUDLY;
                        tmr_load_s     = 1'b1;
                        tmr_load_val_s = CPU_LOAD;
                    end else if (tmr_zero_s) begin
                        state_nxt_s    = ST_FAULT;
                        timeout_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s    = ST_MEMINIT;
                    end
                end
                ST_CPUDLY: begin
                    if (tmr_zero_s) begin
                        state_nxt_s    = ST_RUN;
                        cpu_rstn_nxt_s = 1'b1;
                        ready_nxt_s    = 1'b1;
                    end else begin
                        state_nxt_s    = ST_CPUDLY;
                    end
                end
                ST_RUN: begin
                    state_nxt_s = ST_RUN;
                end
                ST_FAULT: begin
                    state_nxt_s       = ST_FAULT;
                    periph_rstn_nxt_s = 1'b1;
                    cpu_rstn_nxt_s    = 1'b0;
                    ready_nxt_s       = 1'b0;
                end
                default: begin
                    state_nxt_s       = ST_HOLD;
                    periph_rstn_nxt_s = 1'b0;
                    cpu_rstn_nxt_s    = 1'b0;
                    ready_nxt_s       = 1'b0;
                    tmr_load_s        = 1'b1;
                    tmr_load_val_s    = HOLD_LOAD;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r       <= ST_HOLD;
            periph_rstn_r <= 1'b0;
            mem_start_r   <= 1'b0;
            cpu_rstn_r    <= 1'b0;
            ready_r       <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            periph_rstn_r <= periph_rstn_nxt_s;
            mem_start_r   <= mem_start_nxt_s;
            cpu_rstn_r    <= cpu_rstn_nxt_s;
            ready_r       <= ready_nxt_s;
            timeout_r     <= timeout_nxt_s;
        end
    end

    assign periph_rstn_o = periph_rstn_r;
    assign mem_start_o   = mem_start_r;
    assign cpu_rstn_o    = cpu_rstn_r;
    assign ready_o       = ready_r;
    assign timeout_o     = timeout_r;
    assign state_o       = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Table of {inputs, expected outputs} rows, each applied for n cycles; every
// cycle's expectation is queued when the inputs are driven and compared one
// edge later. Hand-written sequences follow for combined abort and mid-run reset.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam logic [2:0] S_HOLD    = 3'd0;
    localparam logic [2:0] S_LOCK    = 3'd1;
    localparam logic [2:0] S_PERIPH  = 3'd2;
    localparam logic [2:0] S_MEMINIT = 3'd3;
    localparam logic [2:0] S_CPUDLY  = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    typedef struct {
        string      name;
        int         n;
        logic       rstn;
        logic       req;
        logic       lock;
        logic       done;
        logic [2:0] st;
        logic       p;
        logic       m;
        logic       c;
        logic       r;
        logic       t;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } sb_t;

    logic       clk_s   = 1'b0;
    logic       rstn_s  = 1'b0;
    logic       req_s   = 1'b0;
    logic       lock_s  = 1'b1;
    logic       done_s  = 1'b0;
    logic       periph_rstn_s;
    logic       mem_start_s;
    logic       cpu_rstn_s;
    logic       ready_s;
    logic       timeout_s;
    logic [2:0] state_s;

    int  n_pass  = 0;
    int  n_total = 0;
    sb_t sb_q[$];
    vec_t tbl[$];

    reset_sequencer dut (
        .clk_i         (clk_s),
        .rst_ni        (rstn_s),
        .req_rst_i     (req_s),
        .pll_lock_i    (lock_s),
        .mem_done_i    (done_s),
        .periph_rstn_o (periph_rstn_s),
        .mem_start_o   (mem_start_s),
        .cpu_rstn_o    (cpu_rstn_s),
        .ready_o       (ready_s),
        .timeout_o     (timeout_s),
        .state_o       (state_s)
    );

    always #5 clk_s = ~clk_s;

    function automatic vec_t mk(input string name, input int n, input logic rstn,
                                input logic req, input logic lock, input logic done,
                                input logic [2:0] st, input logic p, input logic m,
                                input logic c, input logic r, input logic t);
        vec_t v;
        v.name = name; v.n = n; v.rstn = rstn; v.req = req; v.lock = lock; v.done = done;
        v.st = st; v.p = p; v.m = m; v.c = c; v.r = r; v.t = t;
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input vec_t v, input int idx);
        sb_t        e;
        logic [7:0] act;
        rstn_s = v.rstn;
        req_s  = v.req;
        lock_s = v.lock;
        done_s = v.done;
        e.name = $sformatf("%s[%0d]", v.name, idx);
        e.exp  = {v.st, v.p, v.m, v.c, v.r, v.t};
        sb_q.push_back(e);
        @(posedge clk_s);
        #1;
        act = {state_s, periph_rstn_s, mem_start_s, cpu_rstn_s, ready_s, timeout_s};
        n_total++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty at %s", e.name);
        end else begin
            e = sb_q.pop_front();
            if (act === e.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got {st,p,m,c,r,t}=%b want %b", e.name, act, e.exp);
            end
        end
    endtask

    task automatic run_row(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            step(v, i);
        end
    endtask

    initial begin
        // Power-up and normal release
        tbl.push_back(mk("reset",        2, 0,0,1,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("hold_cnt",    15, 1,0,1,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("to_lock",      1, 1,0,1,0, S_LOCK,   0,0,0,0,0));
        tbl.push_back(mk("periph_rel",   1, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("periph_wait",  7, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("mem_start",    1, 1,0,1,0, S_MEMINIT,1,1,0,0,0));
        tbl.push_back(mk("meminit_wait", 4, 1,0,1,0, S_MEMINIT,1,0,0,0,0));
        tbl.push_back(mk("mem_done",     1, 1,0,1,1, S_CPUDLY, 1,0,0,0,0));
        tbl.push_back(mk("cpu_dly",      3, 1,0,1,0, S_CPUDLY, 1,0,0,0,0));
        tbl.push_back(mk("run_rel",      1, 1,0,1,0, S_RUN,    1,0,1,1,0));
        tbl.push_back(mk("run",          3, 1,0,1,0, S_RUN,    1,0,1,1,0));
        // Request held in RUN, then a glitchy release during HOLD
        tbl.push_back(mk("req_abort",   40, 1,1,1,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("hold_glitch", 10, 1,0,1,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("hold_reload",  1, 1,1,1,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("hold_recount",15, 1,0,1,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("to_lock2",     1, 1,0,1,0, S_LOCK,   0,0,0,0,0));
        tbl.push_back(mk("lock_wait",    3, 1,0,0,0, S_LOCK,   0,0,0,0,0));
        tbl.push_back(mk("periph_rel2",  1, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("periph_wait2", 7, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("mem_start2",   1, 1,0,1,0, S_MEMINIT,1,1,0,0,0));
        tbl.push_back(mk("meminit_wt2",  2, 1,0,1,0, S_MEMINIT,1,0,0,0,0));
        tbl.push_back(mk("mem_done2",    1, 1,0,1,1, S_CPUDLY, 1,0,0,0,0));
        tbl.push_back(mk("cpu_dly2",     1, 1,0,1,0, S_CPUDLY, 1,0,0,0,0));
        // One-cycle PLL loss in CPUDLY, relock and repeat
        tbl.push_back(mk("pll_drop",     1, 1,0,0,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("relock_hold", 15, 1,0,1,0, S_HOLD,   0,0,0,0,0));
        tbl.push_back(mk("to_lock3",     1, 1,0,1,0, S_LOCK,   0,0,0,0,0));
        tbl.push_back(mk("periph_rel3",  1, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("periph_wait3", 7, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("mem_start3",   1, 1,0,1,0, S_MEMINIT,1,1,0,0,0));
        // Done during the start pulse is ignored; then timeout into FAULT
        tbl.push_back(mk("done_in_start",1, 1,0,1,1, S_MEMINIT,1,0,0,0,0));
        tbl.push_back(mk("timeout_wait",4094,1,0,1,0,S_MEMINIT,1,0,0,0,0));
        tbl.push_back(mk("fault",        1, 1,0,1,0, S_FAULT,  1,0,0,0,1));
        tbl.push_back(mk("fault_stay",   5, 1,0,1,1, S_FAULT,  1,0,0,0,1));
        tbl.push_back(mk("fault_req",    1, 1,1,1,0, S_HOLD,   0,0,0,0,1));
        tbl.push_back(mk("hold_sticky", 15, 1,0,1,0, S_HOLD,   0,0,0,0,1));
        tbl.push_back(mk("lock_clr",     1, 1,0,1,0, S_LOCK,   0,0,0,0,0));
        // Done arriving on the last timeout cycle wins
        tbl.push_back(mk("periph_rel4",  1, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("periph_wait4", 7, 1,0,1,0, S_PERIPH, 1,0,0,0,0));
        tbl.push_back(mk("mem_start4",   1, 1,0,1,0, S_MEMINIT,1,1,0,0,0));
        tbl.push_back(mk("timeout_wt2",4095,1,0,1,0, S_MEMINIT,1,0,0,0,0));
        tbl.push_back(mk("done_last",    1, 1,0,1,1, S_CPUDLY, 1,0,0,0,0));
        tbl.push_back(mk("cpu_dly4",     3, 1,0,1,0, S_CPUDLY, 1,0,0,0,0));
        tbl.push_back(mk("run_rel4",     1, 1,0,1,0, S_RUN,    1,0,1,1,0));

        for (int k = 0; k < tbl.size(); k++) begin
            run_row(tbl[k]);
        end

        // Request and PLL loss together in RUN: one abort; lock loss in HOLD/LOCK only waits
        step(mk("req_and_pll",  1, 1,1,0,0, S_HOLD,   0,0,0,0,0), 0);
        for (int i = 0; i < 15; i++) begin
            step(mk("hold_nolock", 1, 1,0,0,0, S_HOLD,   0,0,0,0,0), i);
        end
        for (int i = 0; i < 3; i++) begin
            step(mk("lock_nolock", 1, 1,0,0,0, S_LOCK,   0,0,0,0,0), i);
        end
        step(mk("periph_rel5",  1, 1,0,1,0, S_PERIPH, 1,0,0,0,0), 0);
        step(mk("periph_wait5", 1, 1,0,1,0, S_PERIPH, 1,0,0,0,0), 0);

        // Synchronous reset mid-sequence reloads the full HOLD interval
        step(mk("mid_reset",    1, 0,0,1,0, S_HOLD,   0,0,0,0,0), 0);
        for (int i = 0; i < 15; i++) begin
            step(mk("post_rst_hold", 1, 1,0,1,0, S_HOLD, 0,0,0,0,0), i);
        end
        step(mk("post_rst_lock", 1, 1,0,1,0, S_LOCK,   0,0,0,0,0), 0);
        step(mk("post_rst_rel",  1, 1,0,1,0, S_PERIPH, 1,0,0,0,0), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
